// File: rtl/an_sec_pkg.sv
// rtl/an_sec_pkg.sv - shared constants, status codes and states for the AN-code SEC decoder
// Contents: codeword/data widths, AN multiplier, status encoding, FSM state type,
//           and a helper returning 2^k mod m for building the syndrome table.
package an_sec_pkg;

  localparam int CW_W   = 24;
  localparam int A      = 3349;
  localparam int DATA_W = 12;

  localparam logic [1:0] STAT_CLEAN     = 2'b00;
  localparam logic [1:0] STAT_CORRECTED = 2'b01;
  localparam logic [1:0] STAT_UNCORR    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV1,
    S_CORR,
    S_DIV2,
    S_DONE
  } state_t;

  function automatic int pow2_mod(input int k, input int m);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = (p * 2) % m;
    return p;
  endfunction

endpackage

// File: rtl/sec_rlut12bits.sv
// rtl/sec_rlut12bits.sv - remainder-to-error-location table for single +/-2^k errors
// Ports: r   in  12  remainder of codeword mod A
//        loc out 6s  +k when r == 2^(k-1) mod A, -k when r == A - (2^(k-1) mod A), else 0
module SEC_rLUT12bits
  import an_sec_pkg::*;
#(
  parameter int CW_W = an_sec_pkg::CW_W,
  parameter int A    = an_sec_pkg::A
) (
  input  logic        [11:0] r,
  output logic signed [5:0]  loc
);

  always_comb begin
    loc = '0;
    for (int k = 0; k < CW_W; k++) begin
      if (r == 12'(pow2_mod(k, A))) begin
        loc = 6'(k + 1);
      end else if (r == 12'(A - pow2_mod(k, A))) begin
        loc = -6'(k + 1);
      end
    end
  end

endmodule

// File: rtl/an_sec_decode_ctrl.sv
// rtl/an_sec_decode_ctrl.sv - sequential AN-code decoder with single-error correction
// Ports: clk, rst_n (sync, active-low)
//        in_valid/in_ready/in_cw       codeword input handshake
//        out_valid/out_ready           result handshake, result held until taken
//        out_data, out_status, out_loc decoded word, 00/01/10 status, signed error location
module an_sec_decode_ctrl #(
  parameter int CW_W   = an_sec_pkg::CW_W,
  parameter int A      = an_sec_pkg::A,
  parameter int DATA_W = an_sec_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW_W-1:0]     in_cw,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_status,
  output logic signed [5:0]   out_loc
);

  import an_sec_pkg::*;

  state_t            state, state_d;
  logic [4:0]        cnt;
  logic [CW_W-1:0]   cw;    // received codeword, kept for correction
  logic [CW_W-1:0]   sh;    // dividend shifting out, quotient shifting in
  logic [12:0]       rem;   // partial remainder
  logic [DATA_W-1:0] data_q;
  logic [1:0]        status_q;
  logic signed [5:0] loc_q;

  // One restoring-division step, shared by both passes.
  logic [12:0]     shifted, rem_step;
  logic            ge;
  logic [CW_W-1:0] sh_step;

  always_comb begin
    shifted  = {rem[11:0], sh[CW_W-1]};
    ge       = (shifted >= 13'(A));
    rem_step = ge ? (shifted - 13'(A)) : shifted;
    sh_step  = {sh[CW_W-2:0], ge};
  end

  logic signed [5:0] lut_loc;

  SEC_rLUT12bits #(
    .CW_W (CW_W),
    .A    (A)
  ) u_lut (
    .r   (rem[11:0]),
    .loc (lut_loc)
  );

  // Correction: flip the located +/-2^(|l|-1) error. Bit CW_W of the extended
  // result flags a borrow (l > 0) or a carry out of the codeword (l < 0).
  logic [4:0]    mag_idx;
  logic [CW_W:0] mag, cw_fix;
  logic          fix_bad;

  always_comb begin
    // For negative l, ~l == |l|-1 in two's complement.
    mag_idx = lut_loc[5] ? ~lut_loc[4:0] : (lut_loc[4:0] - 5'd1);
    mag     = {{CW_W{1'b0}}, 1'b1} << mag_idx;
    cw_fix  = lut_loc[5] ? ({1'b0, cw} + mag) : ({1'b0, cw} - mag);
    fix_bad = cw_fix[CW_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (in_valid) state_d = S_DIV1;
      S_DIV1: if (cnt == 5'd0) state_d = S_CORR;
      S_CORR: begin
        if (rem != 13'd0 && lut_loc != 6'sd0 && !fix_bad) state_d = S_DIV2;
        else                                              state_d = S_DONE;
      end
      S_DIV2: if (cnt == 5'd0) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      cw       <= '0;
      sh       <= '0;
      rem      <= '0;
      data_q   <= '0;
      status_q <= STAT_CLEAN;
      loc_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            cw  <= in_cw;
            sh  <= in_cw;
            rem <= '0;
            cnt <= 5'(CW_W - 1);
          end
        end
        S_DIV1, S_DIV2: begin
          sh  <= sh_step;
          rem <= rem_step;
          cnt <= (cnt == 5'd0) ? 5'd0 : (cnt - 5'd1);
          if (state == S_DIV2 && cnt == 5'd0) begin
            data_q   <= sh_step[DATA_W-1:0];
            status_q <= ((rem_step != 13'd0) || (|sh_step[CW_W-1:DATA_W]))
                        ? STAT_UNCORR : STAT_CORRECTED;
          end
        end
        S_CORR: begin
          data_q <= sh[DATA_W-1:0];
          if (rem == 13'd0) begin
            status_q <= (|sh[CW_W-1:DATA_W]) ? STAT_UNCORR : STAT_CLEAN;
            loc_q    <= '0;
          end else if (lut_loc == 6'sd0) begin
            status_q <= STAT_UNCORR;
            loc_q    <= '0;
          end else begin
            loc_q <= lut_loc;
            if (fix_bad) begin
              status_q <= STAT_UNCORR;
            end else begin
              sh  <= cw_fix[CW_W-1:0];
              rem <= '0;
              cnt <= 5'(CW_W - 1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = rst_n && (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_data   = data_q;
  assign out_status = status_q;
  assign out_loc    = loc_q;

endmodule

// File: tb/tb_an_sec_decode_ctrl.sv
// tb/tb_an_sec_decode_ctrl.sv - directed self-checking bench for an_sec_decode_ctrl
module tb_an_sec_decode_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [23:0]       in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [11:0]       out_data;
  logic [1:0]        out_status;
  logic signed [5:0] out_loc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  an_sec_decode_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cw      (in_cw),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .out_loc    (out_loc)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one codeword, keep in_valid high with junk while busy, time the
  // result, check it, optionally stall out_ready, then take it.
  task automatic decode(input string tag, input logic [23:0] cw, input int exp_lat,
                        input int exp_data, input int exp_stat, input int exp_loc,
                        input int hold);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_cw    = cw;
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_cw = 24'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      in_cw = 24'($urandom);
    end while (!out_valid && n < 200);
    in_valid = 1'b0;
    chk({tag, ".latency"}, n, exp_lat);
    chk({tag, ".data"}, 32'(out_data), exp_data);
    chk({tag, ".status"}, 32'(out_status), exp_stat);
    chk({tag, ".loc"}, int'(out_loc), exp_loc);
    chk({tag, ".busy_ready"}, 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(out_valid), 1);
      chk({tag, ".hold_data"}, 32'(out_data), exp_data);
      chk({tag, ".hold_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".taken_valid"}, 32'(out_valid), 0);
    chk({tag, ".taken_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.out_data", 32'(out_data), 0);
    chk("rst.out_status", 32'(out_status), 0);
    chk("rst.out_loc", int'(out_loc), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel.in_ready", 32'(in_ready), 1);

    // tag, codeword, latency, data, status, loc, stall cycles
    decode("clean_1",     24'd3349,     26, 1,    0, 0,   10);
    decode("plus1",       24'd3350,     50, 1,    1, 1,   0);
    decode("minus4096",   24'd2602,     50, 2,    1, -13, 0);
    decode("uncorr_r3",   24'd3352,     26, 1,    2, 0,   0);
    decode("uncorr_max",  24'd16777215, 26, 913,  2, 0,   0);
    decode("msb_on_zero", 24'd8388608,  50, 0,    1, 24,  0);
    decode("clean_4095",  24'd13714155, 26, 4095, 0, 0,   0);
    decode("borrow",      24'd747,      26, 0,    2, 13,  0);
    decode("carry",       24'd16775778, 26, 913,  2, -24, 0);

    // Abort a codeword in cycle 12 of DIV1.
    @(negedge clk);
    in_valid = 1'b1;
    in_cw    = 24'd3350;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort.in_ready_low", 32'(in_ready), 0);
    chk("abort.out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort.in_ready_rel", 32'(in_ready), 1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort.no_result", seen, 0);
    end
    decode("after_abort", 24'd2602, 50, 2, 1, -13, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/an_sec_decode_ctrl.md
AN_SEC_DECODE_CTRL -- requirements
Module: an_sec_decode_ctrl

Interface
REQ-001 Parameter CW_W, 24, codeword width in bits.
REQ-002 Parameter A, 3349, AN-code multiplier, 12-bit constant.
REQ-003 Parameter DATA_W, 12, decoded data width; legal data range 0..4095.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port in_valid  input  1  codeword offered.
REQ-007 Port in_ready  output  1  block accepts a codeword; high only in IDLE.
REQ-008 Port in_cw  input  CW_W  received codeword, unsigned.
REQ-009 Port out_valid  output  1  result available; held until taken.
REQ-010 Port out_ready  input  1  downstream accepts result.
REQ-011 Port out_data  output  DATA_W  decoded data word.
REQ-012 Port out_status  output  2  00 CLEAN, 01 CORRECTED, 10 UNCORRECTABLE; 11 never driven.
REQ-013 Port out_loc  output  6 signed  error location (+k: error +2^(k-1); -k: error -2^(k-1)); 0 if none.

Function
REQ-014 States: IDLE, DIV1, CORR, DIV2, DONE; 5-bit bit counter.
REQ-015 IDLE: in_valid && in_ready captures in_cw into the working register; next state DIV1; counter = CW_W-1.
REQ-016 DIV1/DIV2: restoring division by A, one quotient bit per cycle, MSB first; 13-bit partial remainder; exactly CW_W (24) cycles per pass.
REQ-017 After DIV1: remainder r (12 bits) and quotient q1 (13 bits) are registered; next state CORR.
REQ-018 CORR (1 cycle): r == 0 -> status CLEAN, data q1, loc 0, next DONE (DIV2 skipped).
REQ-019 CORR: r != 0 and LUT location l == 0 -> status UNCORRECTABLE, data q1[11:0], loc 0, next DONE.
REQ-020 CORR: l > 0 -> corrected cw = cw - 2^(l-1); l < 0 -> cw + 2^(|l|-1); loc = l; next DIV2.
REQ-021 CORR: borrow below 0 or carry beyond 2^CW_W during correction -> UNCORRECTABLE, loc = l, data q1[11:0], next DONE.
REQ-022 After DIV2: status CORRECTED, data = quotient; non-zero pass-2 remainder -> UNCORRECTABLE.
REQ-023 Any final quotient > 4095 -> UNCORRECTABLE; out_data = quotient[11:0].
REQ-024 DONE: out_valid = 1, outputs stable; out_valid && out_ready -> IDLE on that edge.
REQ-025 Latency, acceptance edge to first out_valid cycle: 26 cycles (DIV2 skipped), 50 cycles (DIV2 run).
REQ-026 No overlap: in_ready = 0 in DIV1, CORR, DIV2, DONE; at most one codeword in flight.
REQ-027 in_valid ignored outside IDLE; in_cw sampled only on acceptance edge.
REQ-028 out_ready ignored outside DONE.

Reset
REQ-029 rst_n low at a rising edge -> state IDLE, counter 0, out_valid 0, out_data 0, out_status 00, out_loc 0; working registers cleared.
REQ-030 in_ready = 0 while rst_n is low; = 1 in the first cycle after release.
REQ-031 Reset mid-operation (any state) aborts the codeword; no result is ever emitted for it.

Structure
REQ-032 Package an_sec_pkg: CW_W, A, DATA_W, status encoding constants, state enumeration.
REQ-033 One sub-module: existing SEC_rLUT12bits, driven by registered r, output consumed in CORR.
REQ-034 Single shared divider datapath for DIV1 and DIV2; no second divider.

Verification
REQ-035 Clean: in_cw=3349 -> data 1, CLEAN, loc 0, out_valid 26 cycles after acceptance.
REQ-036 +1 error: in_cw=3350 -> r=1, loc +1, data 1, CORRECTED, latency 50.
REQ-037 -2^12 error: in_cw=2602 (6698-4096) -> loc -13, data 2, CORRECTED.
REQ-038 Uncorrectable: in_cw=3352 -> r=3, UNCORRECTABLE, loc 0, data 1; in_cw=16777215 -> UNCORRECTABLE.
REQ-039 MSB error on zero: in_cw=8388608 -> r=2712, loc +24, data 0, CORRECTED; in_cw=13714155 -> data 4095, CLEAN.
REQ-040 Handshake/reset: out_ready low 10 cycles -> outputs held, in_ready 0; rst_n low in cycle 12 of DIV1 -> IDLE, no out_valid, next codeword decodes correctly.
